// File: rtl/dbus_mem_responder_pkg.sv
// dbus_mem_responder_pkg: shared dbus request/response types, responder state and LFSR width.
`default_nettype none

package dbus_mem_responder_pkg;

  localparam int DBUS_LFSR_W = 16;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } resp_state_e;

  function automatic logic [63:0] strobe_merge(input logic [63:0] old_word,
                                               input logic [63:0] new_word,
                                               input logic [7:0]  strobe);
    logic [63:0] merged;
    for (int i = 0; i < 8; i++) begin
      merged[i*8 +: 8] = strobe[i] ? new_word[i*8 +: 8] : old_word[i*8 +: 8];
    end
    return merged;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dbus_lat_lfsr.sv
// dbus_lat_lfsr: 16-bit Fibonacci LFSR (taps 16,14,13,11), steps once per enable.
`default_nettype none

`ifdef DBUS_RAND_LAT_EN
module dbus_lat_lfsr
  import dbus_mem_responder_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [DBUS_LFSR_W-1:0] seed,
  output logic [DBUS_LFSR_W-1:0] state
);

  logic feedback;

  assign feedback = state[15] ^ state[13] ^ state[12] ^ state[10];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= seed;
    end else if (enable) begin
      state <= {state[DBUS_LFSR_W-2:0], feedback};
    end
  end

endmodule
`endif

`default_nettype wire

// File: rtl/dbus_mem_responder.sv
// dbus_mem_responder: dbus slave memory with byte-strobed writes and fixed response latency.
// Optional: define DBUS_RAND_LAT_EN to add 0-3 LFSR-driven extra latency cycles per request.
`default_nettype none

module dbus_mem_responder
  import dbus_mem_responder_pkg::*;
#(
  parameter int                     DEPTH     = 4096,
  parameter int                     LATENCY   = 2,
  parameter logic [DBUS_LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 4) + 1;

  logic [63:0] mem [DEPTH];

  resp_state_e      state;
  resp_state_e      state_nxt;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] load_cnt;
  logic             accept;

  logic [IDX_W-1:0] idx_q;
  logic [7:0]       strobe_q;
  logic [63:0]      wdata_q;
  logic [IDX_W-1:0] idx_src;
  logic [7:0]       strobe_src;
  logic [63:0]      wdata_src;
  logic [63:0]      merged;

  logic             data_ok_q;
  logic [63:0]      data_q;
  logic             unused_bits;

  assign accept = (state == IDLE) && dreq.valid;

`ifdef DBUS_RAND_LAT_EN
  logic [DBUS_LFSR_W-1:0] lfsr;

  dbus_lat_lfsr u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .enable (accept),
    .seed   (LFSR_SEED),
    .state  (lfsr)
  );

  assign load_cnt    = CNT_W'(LATENCY) + CNT_W'(lfsr[1:0]);
  assign unused_bits = ^{dreq.size, dreq.addr[63:IDX_W+3], dreq.addr[2:0], lfsr[DBUS_LFSR_W-1:2]};
`else
  assign load_cnt    = CNT_W'(LATENCY);
  assign unused_bits = ^{dreq.size, dreq.addr[63:IDX_W+3], dreq.addr[2:0], LFSR_SEED};
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (dreq.valid) begin
          state_nxt = (load_cnt == '0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (counter <= CNT_W'(1)) begin
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic; addr_ok is held low while reset is asserted even though the FSM sits in IDLE.
  always_comb begin
    dresp         = '0;
    dresp.addr_ok = reset && accept;
    dresp.data_ok = data_ok_q;
    dresp.data    = data_q;
  end

  // With zero latency the response is formed in the accepting cycle, so source from dreq there.
  always_comb begin
    if (state == IDLE) begin
      idx_src    = dreq.addr[IDX_W+2:3];
      strobe_src = dreq.strobe;
      wdata_src  = dreq.data;
    end else begin
      idx_src    = idx_q;
      strobe_src = strobe_q;
      wdata_src  = wdata_q;
    end
    merged = strobe_merge(mem[idx_src], wdata_src, strobe_src);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      counter   <= '0;
      idx_q     <= '0;
      strobe_q  <= '0;
      wdata_q   <= '0;
      data_ok_q <= 1'b0;
      data_q    <= '0;
    end else begin
      if (accept) begin
        counter  <= load_cnt;
        idx_q    <= dreq.addr[IDX_W+2:3];
        strobe_q <= dreq.strobe;
        wdata_q  <= dreq.data;
      end else if (state == WAIT) begin
        counter <= counter - CNT_W'(1);
      end
      data_ok_q <= (state_nxt == RESP);
      if (state_nxt == RESP) begin
        data_q <= merged;
      end
    end
  end

  // data_q already holds the merged word, so the commit is a plain store at the end of RESP.
  always_ff @(posedge clk) begin
    if ((state == RESP) && (strobe_q != 8'h00)) begin
      mem[idx_q] <= data_q;
    end
  end

endmodule

`default_nettype wire
